// File: rtl/door_lock_pkg.sv
// Shared types and constants for the serial combination-lock controller.
package door_lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    ERROR   = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  localparam int DEFAULT_CODE_LEN = 4;
  localparam logic [DEFAULT_CODE_LEN-1:0] DEFAULT_CODE = 4'b1010;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/door_lock_timer.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
module door_lock_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/door_lock_fsm.sv
// Serial combination-lock controller, code entered MSB first on B.
// Optional build macro: DOOR_LOCK_AUTO_RELOCK_EN -- when defined, OPEN lasts
// OPEN_CYCLES cycles and returns to IDLE; otherwise OPEN holds until Rst.
//
// state   | meaning
// IDLE    | waiting for the leading 1 of a code (zeros ignored)
// ENTRY   | comparing remaining code bits, idx_q points at the expected bit
// OPEN    | door unlocked, Out=1
// ERROR   | failed attempt, Err=1 for ERR_CYCLES cycles
// LOCKOUT | MAX_FAILS consecutive failures, Err=1 until Rst
module door_lock_fsm
  import door_lock_pkg::*;
#(
  parameter int                  CODE_LEN    = DEFAULT_CODE_LEN,
  parameter logic [CODE_LEN-1:0] CODE        = DEFAULT_CODE,
  parameter int                  OPEN_CYCLES = 4,
  parameter int                  ERR_CYCLES  = 2,
  parameter int                  MAX_FAILS   = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic B,
  output logic Out,
  output logic Err
);

  localparam int IW = $clog2(CODE_LEN);
  localparam int FW = cnt_width(MAX_FAILS);
  localparam int TW = cnt_width((OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [FW-1:0] fail_inc;
  logic          out_q, out_d;
  logic          err_q, err_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  door_lock_timer #(.W(TW)) u_timer (
    .clk      (Clk),
    .rst      (Rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign fail_inc = fail_q + 1'b1;

  // Next-state, index, fail count and timer load decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (B) begin
          state_d = ENTRY;
          idx_d   = IW'(CODE_LEN - 2);
        end
      end
      ENTRY: begin
        if (B == CODE[idx_q]) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
            state_d = OPEN;
            fail_d  = '0;
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
            tmr_load = 1'b1;
            tmr_val  = TW'(OPEN_CYCLES - 1);
`endif
          end
        end else begin
          if (fail_q != FW'(MAX_FAILS)) fail_d = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_d = LOCKOUT;
          end else begin
            state_d  = ERROR;
            tmr_load = 1'b1;
            tmr_val  = TW'(ERR_CYCLES - 1);
          end
        end
      end
      OPEN: begin
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
        if (tmr_zero) state_d = IDLE;
`else
        state_d = OPEN;
`endif
      end
      ERROR: begin
        if (tmr_zero) state_d = IDLE;
      end
      LOCKOUT: state_d = LOCKOUT;
      default: state_d = IDLE;
    endcase
    // Outputs follow the state being entered so they line up with state_q.
    out_d = (state_d == OPEN);
    err_d = (state_d == ERROR) || (state_d == LOCKOUT);
  end

  // State, index, fail count and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fail_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign Out = out_q;
  assign Err = err_q;

endmodule

// File: tb/tb_door_lock_fsm.sv
// Directed bench for door_lock_fsm (default CODE=1010, ERR_CYCLES=2, MAX_FAILS=3).
module tb_door_lock_fsm;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic B   = 1'b0;
  logic Out, Err;

  int n_checks = 0;
  int n_fail   = 0;

  door_lock_fsm dut (
    .Clk (Clk),
    .Rst (Rst),
    .B   (B),
    .Out (Out),
    .Err (Err)
  );

  always #5 Clk = ~Clk;

  // Present one bit, let one rising edge sample it, settle 1 ns after.
  task automatic step(input logic b);
    B = b;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Rst = 1'b1;
    step(1'b0);
    Rst = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) step(bits[i]);
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    step(1'b1);
    step(1'b0);
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL reset_hold: {Out,Err}=%b expected 00", {Out, Err});
    end
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      n_checks++;
      if ({Out, Err} !== 2'b00) begin
        n_fail++; $display("FAIL reset_idle_zeros[%0d]: {Out,Err}=%b expected 00", i, {Out, Err});
      end
    end
  endtask

  task automatic test_correct_code;
    do_reset();
    step(1'b1); step(1'b0); step(1'b1);
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL open_early: {Out,Err}=%b expected 00", {Out, Err});
    end
    step(1'b0);
    n_checks++;
    if ({Out, Err} !== 2'b10) begin
      n_fail++; $display("FAIL open_first: {Out,Err}=%b expected 10", {Out, Err});
    end
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
    for (int i = 1; i < 4; i++) begin
      step(1'b1);
      n_checks++;
      if ({Out, Err} !== 2'b10) begin
        n_fail++; $display("FAIL open_hold[%0d]: {Out,Err}=%b expected 10", i, {Out, Err});
      end
    end
    step(1'b0);
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL open_relock: {Out,Err}=%b expected 00", {Out, Err});
    end
`else
    for (int i = 1; i < 10; i++) begin
      step(i[0]);
      n_checks++;
      if ({Out, Err} !== 2'b10) begin
        n_fail++; $display("FAIL open_terminal[%0d]: {Out,Err}=%b expected 10", i, {Out, Err});
      end
    end
`endif
    do_reset();
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL open_rst: {Out,Err}=%b expected 00", {Out, Err});
    end
  endtask

  task automatic test_wrong_bit;
    do_reset();
    step(1'b1);
    step(1'b1);
    n_checks++;
    if ({Out, Err} !== 2'b01) begin
      n_fail++; $display("FAIL err_first: {Out,Err}=%b expected 01", {Out, Err});
    end
    step(1'b1);
    n_checks++;
    if ({Out, Err} !== 2'b01) begin
      n_fail++; $display("FAIL err_second: {Out,Err}=%b expected 01", {Out, Err});
    end
    step(1'b0);
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL err_end: {Out,Err}=%b expected 00", {Out, Err});
    end
    enter4(4'b1010);
    n_checks++;
    if ({Out, Err} !== 2'b10) begin
      n_fail++; $display("FAIL err_then_open: {Out,Err}=%b expected 10", {Out, Err});
    end
  endtask

  task automatic test_lockout;
    do_reset();
    for (int a = 1; a <= 3; a++) begin
      step(1'b1); step(1'b1);
      n_checks++;
      if ({Out, Err} !== 2'b01) begin
        n_fail++; $display("FAIL lock_fail%0d: {Out,Err}=%b expected 01", a, {Out, Err});
      end
      step(1'b0); step(1'b0);
      n_checks++;
      if ({Out, Err} !== ((a == 3) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL lock_after%0d: {Out,Err}=%b expected %b", a, {Out, Err},
                           (a == 3) ? 2'b01 : 2'b00);
      end
    end
    enter4(4'b1010);
    n_checks++;
    if ({Out, Err} !== 2'b01) begin
      n_fail++; $display("FAIL lock_ignores_code: {Out,Err}=%b expected 01", {Out, Err});
    end
    do_reset();
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL lock_rst: {Out,Err}=%b expected 00", {Out, Err});
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    step(1'b1); step(1'b0);
    Rst = 1'b1;
    step(1'b1);
    Rst = 1'b0;
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL mid_rst: {Out,Err}=%b expected 00", {Out, Err});
    end
    enter4(4'b1010);
    n_checks++;
    if ({Out, Err} !== 2'b10) begin
      n_fail++; $display("FAIL mid_then_open: {Out,Err}=%b expected 10", {Out, Err});
    end
    do_reset();
    step(1'b1); step(1'b1);
    Rst = 1'b1;
    step(1'b0);
    Rst = 1'b0;
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL error_rst: {Out,Err}=%b expected 00", {Out, Err});
    end
    // Two failures, reset, two more: reset must have cleared the count.
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    do_reset();
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    n_checks++;
    if ({Out, Err} !== 2'b00) begin
      n_fail++; $display("FAIL rst_clears_fails: {Out,Err}=%b expected 00", {Out, Err});
    end
  endtask

  task automatic test_fail_clear;
    do_reset();
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    enter4(4'b1010);
    n_checks++;
    if ({Out, Err} !== 2'b10) begin
      n_fail++; $display("FAIL clr_open: {Out,Err}=%b expected 10", {Out, Err});
    end
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
    step(1'b0); step(1'b0); step(1'b0); step(1'b0);
    for (int a = 1; a <= 2; a++) begin
      step(1'b1); step(1'b1);
      n_checks++;
      if ({Out, Err} !== 2'b01) begin
        n_fail++; $display("FAIL clr_fail%0d: {Out,Err}=%b expected 01", a, {Out, Err});
      end
      step(1'b0); step(1'b0);
      n_checks++;
      if ({Out, Err} !== 2'b00) begin
        n_fail++; $display("FAIL clr_no_lock%0d: {Out,Err}=%b expected 00", a, {Out, Err});
      end
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_bit();
    test_lockout();
    test_reset_mid();
    test_fail_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/door_lock_fsm.md
Name: door_lock_fsm

Overview:
- Serial combination-lock controller. The code is entered one bit per clock on `B`, MSB first.
- A correct full sequence asserts `Out` (door unlocked). A wrong bit asserts `Err`.
- Repeated failures drive the block into a lockout that only `Rst` clears.
- Leaf block between the keypad/button debouncer and the lock actuator/indicator LEDs.

Parameters:
- CODE_LEN, 4, number of code bits (2..16).
- CODE, 4'b1010, unlock code, entered MSB first; CODE[CODE_LEN-1] must be 1.
- OPEN_CYCLES, 4, cycles `Out` stays high in auto-relock mode (>=1).
- ERR_CYCLES, 2, cycles `Err` pulses after a failed attempt (>=1).
- MAX_FAILS, 3, consecutive failed attempts before permanent lockout (>=1).

Ports:
- Clk  input  1  system clock; rising edge active.
- Rst  input  1  synchronous, active-high reset.
- B    input  1  serial code bit, sampled every rising edge; already synchronised and debounced upstream.
- Out  output 1  unlock indication, registered.
- Err  output 1  error/lockout indication, registered.

Behaviour:
- One clock; reset is synchronous and active-high. Rst sampled high at a rising edge sets: state=IDLE, bit index=0, fail count=0, Out=0, Err=0. This applies from any state, including mid-entry, OPEN, ERROR and LOCKOUT.
- Moore machine. Out and Err decode from the state register only; no combinational path from B to either output.
- States: IDLE, ENTRY, OPEN, ERROR, LOCKOUT.
- IDLE:
  - B=0: stay in IDLE (leading zeros ignored).
  - B=1: matches CODE MSB; go to ENTRY with index=CODE_LEN-2.
- ENTRY, each edge, compare B with CODE[index]:
  - Match and index>0: decrement index.
  - Match and index=0: go to OPEN and clear fail count.
  - Mismatch: increment fail count. If the new count equals MAX_FAILS, go to LOCKOUT; otherwise go to ERROR.
- OPEN: Out=1, Err=0. B is ignored. Exit depends on DOOR_LOCK_AUTO_RELOCK_EN (see Optional Feature).
- ERROR:
  - Err=1 for exactly ERR_CYCLES cycles, then return to IDLE.
  - B is ignored while in ERROR; a new attempt starts only from IDLE.
- LOCKOUT: Err=1, Out=0. Held until Rst; all B activity is ignored.
- Latency: Out rises on the edge that samples the last correct bit, i.e. visible one cycle after that bit is presented. Err follows the same rule for the mismatching bit.
- Out and Err are never high simultaneously.
- The fail counter is ceil(log2(MAX_FAILS+1)) bits wide and saturates at MAX_FAILS.
- A successful unlock resets the fail count to 0.
- A failure consumes the attempt; bits already entered are discarded.

Optional Feature:
- Macro: DOOR_LOCK_AUTO_RELOCK_EN.
- Defined:
  - OPEN holds `Out`=1 for exactly OPEN_CYCLES cycles, then returns to IDLE. A relock timer counts down in OPEN.
  - A new entry may begin the cycle after return to IDLE.
- Undefined:
  - OPEN is terminal until Rst; `Out` stays 1 indefinitely.
  - The relock timer logic is not compiled.

Decomposition:
- Package door_lock_pkg: state enum typedef (IDLE, ENTRY, OPEN, ERROR, LOCKOUT), default CODE/CODE_LEN constants, and the counter-width function.
- One natural sub-module, door_lock_timer: loadable down-counter with a zero flag. It is shared for the ERR_CYCLES hold and, when the macro is defined, the OPEN_CYCLES hold.
- All other logic stays in door_lock_fsm.

Test Plan:
- Reset: Rst=1 for 2 edges with B toggling -> Out=0, Err=0, state IDLE. Release, then B=0 for 5 cycles -> Out and Err remain 0.
- Correct code: B=1,0,1,0 on consecutive edges -> Out=1 starting the cycle after the 4th bit, Err=0. With the macro, Out=1 for exactly 4 cycles, then 0. Without it, Out stays 1 until Rst.
- Wrong bit: B=1,1 -> Err=1 for 2 cycles starting after the 2nd bit, then Err=0 in IDLE. A following B=1,0,1,0 then opens (Out=1).
- Lockout: three failed attempts (1,1 ×3) -> Err held 1 after the 3rd failure. A subsequent correct code 1,0,1,0 gives Out=0, Err=1. Rst=1 clears both to 0.
- Reset mid-operation: Rst=1 after B=1,0 (mid-entry) -> next cycle Out=0, Err=0, and fail count unchanged at 0. A fresh 1,0,1,0 opens. Rst during OPEN or ERROR clears the output in the next cycle.
- Fail-count clear: one failure, then a correct code, then two failures -> no lockout (Err pulses only, ERR_CYCLES=2 each).
